// File: rtl/multi_image_boot_ctrl.sv
// Post-reset boot image selector: waits out the startup delay, samples boot_sel,
// and loads the chosen image address into the remote-update core before triggering it.
module multi_image_boot_ctrl #(
    parameter int                    IMAGE_NUM     = 4,
    parameter int                    SEL_WIDTH     = 2,
    parameter int                    ADDR_WIDTH    = 24,
    parameter logic [ADDR_WIDTH-1:0] IMAGE_BASE    = ADDR_WIDTH'(24'h000000),
    parameter logic [ADDR_WIDTH-1:0] IMAGE_STRIDE  = ADDR_WIDTH'(24'h100000),
    parameter int                    STARTUP_DELAY = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_WIDTH-1:0]  boot_sel,
    input  logic                  boot_req,
    input  logic                  ru_busy,
    output logic                  ru_write,
    output logic [ADDR_WIDTH-1:0] ru_address,
    output logic                  ru_reconfig,
    output logic                  busy,
    output logic                  sel_error,
    output logic [SEL_WIDTH-1:0]  image_index
);

    localparam logic [2:0] ST_DELAY     = 3'd0;
    localparam logic [2:0] ST_SAMPLE    = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_WAIT_LOAD = 3'd3;
    localparam logic [2:0] ST_TRIGGER   = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam int             CNT_W       = $clog2(STARTUP_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [31:0]    IMAGE_NUM_U = 32'(IMAGE_NUM);

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  wl_first;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign sel_valid = (32'(boot_sel) < IMAGE_NUM_U);
    assign sel_addr  = IMAGE_BASE + ADDR_WIDTH'(boot_sel) * IMAGE_STRIDE;

    // Strobes are decoded from state so each lasts exactly one cycle; gating with
    // reset keeps a pending LOAD/TRIGGER from leaking a pulse while reset is held.
    assign ru_write    = (state == ST_LOAD) && !ru_busy && !reset;
    assign ru_reconfig = (state == ST_TRIGGER) && !reset;
    assign busy        = (state != ST_DONE);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_DELAY;
            cnt         <= '0;
            wl_first    <= 1'b0;
            ru_address  <= IMAGE_BASE;
            image_index <= '0;
            sel_error   <= 1'b0;
        end else begin
            case (state)
                ST_DELAY: begin
                    if (cnt == CNT_LAST) state <= ST_SAMPLE;
                    else                 cnt   <= cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    if (!sel_valid) begin
                        sel_error <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        sel_error   <= 1'b0;
                        image_index <= boot_sel;
                        if (boot_sel == '0) begin
                            state <= ST_DONE;
                        end else begin
                            ru_address <= sel_addr;
                            state      <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!ru_busy) begin
                        wl_first <= 1'b1;
                        state    <= ST_WAIT_LOAD;
                    end
                end
                // First cycle is blind: the core may not raise busy until after the write.
                ST_WAIT_LOAD: begin
                    if (wl_first)     wl_first <= 1'b0;
                    else if (!ru_busy) state   <= ST_TRIGGER;
                end
                ST_TRIGGER: state <= ST_HALT;
                ST_HALT:    state <= ST_HALT;
                ST_DONE: begin
                    if (boot_req) state <= ST_SAMPLE;
                end
                default: begin
                    state <= ST_DELAY;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_image_boot_ctrl.sv
// Directed bench for multi_image_boot_ctrl with IMAGE_NUM=3 and STARTUP_DELAY=10;
// expected values are hand-derived cycle counts and addresses.
module tb_multi_image_boot_ctrl;

    localparam int D = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  boot_sel;
    logic        boot_req;
    logic        ru_busy;
    logic        ru_write;
    logic [23:0] ru_address;
    logic        ru_reconfig;
    logic        busy;
    logic        sel_error;
    logic [1:0]  image_index;

    int n_cmp = 0;
    int n_bad = 0;

    // Monotonic strobe counters; tests take snapshots instead of clearing them.
    int wr_total = 0;
    int rc_total = 0;
    int both_total = 0;
    int wr_base, rc_base;

    always #5 clk = ~clk;

    multi_image_boot_ctrl #(
        .IMAGE_NUM(3), .SEL_WIDTH(2), .ADDR_WIDTH(24),
        .IMAGE_BASE(24'h000000), .IMAGE_STRIDE(24'h100000), .STARTUP_DELAY(D)
    ) dut (
        .clk(clk), .reset(reset), .boot_sel(boot_sel), .boot_req(boot_req),
        .ru_busy(ru_busy), .ru_write(ru_write), .ru_address(ru_address),
        .ru_reconfig(ru_reconfig), .busy(busy), .sel_error(sel_error),
        .image_index(image_index)
    );

    always @(negedge clk) begin
        if (ru_write)                wr_total++;
        if (ru_reconfig)             rc_total++;
        if (ru_write && ru_reconfig) both_total++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        check({tag, "_rst_busy"}, 32'(busy), 32'd1);
        check({tag, "_rst_wr"}, 32'(ru_write), 32'd0);
        check({tag, "_rst_rc"}, 32'(ru_reconfig), 32'd0);
        check({tag, "_rst_addr"}, 32'(ru_address), 32'h000000);
        check({tag, "_rst_idx"}, 32'(image_index), 32'd0);
        check({tag, "_rst_err"}, 32'(sel_error), 32'd0);
        reset = 1'b0;
        wr_base = wr_total;
        rc_base = rc_total;
    endtask

    initial begin
        reset = 1'b1; boot_sel = 2'd0; boot_req = 1'b0; ru_busy = 1'b0;
        tick(2);

        // Image 2, core idle: full load/trigger sequence, then HALT.
        boot_sel = 2'd2;
        do_reset("t1");
        tick(D);
        check("t1_sample_busy", 32'(busy), 32'd1);
        check("t1_sample_wr", 32'(ru_write), 32'd0);
        tick();
        check("t1_load_wr", 32'(ru_write), 32'd1);
        check("t1_load_addr", 32'(ru_address), 32'h200000);
        check("t1_load_idx", 32'(image_index), 32'd2);
        tick();
        check("t1_wl_wr", 32'(ru_write), 32'd0);
        tick();
        check("t1_wl2_rc", 32'(ru_reconfig), 32'd0);
        tick();
        check("t1_trig_rc", 32'(ru_reconfig), 32'd1);
        tick();
        check("t1_halt_rc", 32'(ru_reconfig), 32'd0);
        boot_req = 1'b1; tick(); boot_req = 1'b0;
        tick(10);
        check("t1_halt_busy", 32'(busy), 32'd1);
        check("t1_wr_cnt", 32'(wr_total - wr_base), 32'd1);
        check("t1_rc_cnt", 32'(rc_total - rc_base), 32'd1);

        // Image 0: no strobes, DONE right after SAMPLE.
        boot_sel = 2'd0;
        do_reset("t2");
        tick(D);
        check("t2_sample_busy", 32'(busy), 32'd1);
        tick();
        check("t2_done_busy", 32'(busy), 32'd0);
        check("t2_idx", 32'(image_index), 32'd0);
        tick(3);
        check("t2_wr_cnt", 32'(wr_total - wr_base), 32'd0);
        check("t2_rc_cnt", 32'(rc_total - rc_base), 32'd0);

        // Out-of-range select, then runtime request for image 1.
        boot_sel = 2'd3;
        do_reset("t3");
        tick(D + 1);
        check("t3_err", 32'(sel_error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_idx", 32'(image_index), 32'd0);
        tick(3);
        check("t3_wr_cnt", 32'(wr_total - wr_base), 32'd0);
        boot_sel = 2'd1; boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        check("t3_req_busy", 32'(busy), 32'd1);
        tick();
        check("t3_err_clr", 32'(sel_error), 32'd0);
        check("t3_addr", 32'(ru_address), 32'h100000);
        check("t3_wr", 32'(ru_write), 32'd1);
        check("t3_idx1", 32'(image_index), 32'd1);
        tick(3);
        check("t3_rc", 32'(ru_reconfig), 32'd1);
        tick();
        check("t3_rc_cnt", 32'(rc_total - rc_base), 32'd1);

        // Core busy for 20 cycles in LOAD, then 5 cycles after the write.
        boot_sel = 2'd1; ru_busy = 1'b1;
        do_reset("t4");
        tick(D + 1);
        tick(19);
        check("t4_load_hold_wr", 32'(wr_total - wr_base), 32'd0);
        ru_busy = 1'b0; #1;
        check("t4_wr_on_idle", 32'(ru_write), 32'd1);
        tick();
        ru_busy = 1'b1;
        tick(5);
        check("t4_wl_hold_rc", 32'(rc_total - rc_base), 32'd0);
        ru_busy = 1'b0; #1;
        check("t4_wl_last_rc", 32'(ru_reconfig), 32'd0);
        tick();
        check("t4_trig_rc", 32'(ru_reconfig), 32'd1);
        tick();
        check("t4_halt_rc", 32'(ru_reconfig), 32'd0);
        check("t4_wr_cnt", 32'(wr_total - wr_base), 32'd1);

        // Reset during WAIT_LOAD: abort, then a clean restart.
        boot_sel = 2'd2; ru_busy = 1'b0;
        do_reset("t5");
        tick(D + 1);
        tick();
        do_reset("t5mid");
        check("t5_abort_rc", 32'(rc_total), 32'(rc_base));
        tick(D);
        check("t5_delay_wr", 32'(wr_total - wr_base), 32'd0);
        tick();
        check("t5_restart_wr", 32'(ru_write), 32'd1);
        tick(3);
        check("t5_restart_rc", 32'(ru_reconfig), 32'd1);
        tick();
        check("t5_rc_cnt", 32'(rc_total - rc_base), 32'd1);

        check("no_overlap", 32'(both_total), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_image_boot_ctrl.md
MULTI_IMAGE_BOOT_CTRL -- requirements
Module: multi_image_boot_ctrl

Interface
REQ-001 SHALL provide parameter IMAGE_NUM, default 4, number of selectable configuration images (legal 2..16).
REQ-002 SHALL provide parameter SEL_WIDTH, default 2, width of boot_sel (2^SEL_WIDTH >= IMAGE_NUM).
REQ-003 SHALL provide parameter ADDR_WIDTH, default 24, width of ru_address.
REQ-004 SHALL provide parameter IMAGE_BASE, default 24'h000000, flash address of image 0.
REQ-005 SHALL provide parameter IMAGE_STRIDE, default 24'h100000, address spacing between images.
REQ-006 SHALL provide parameter STARTUP_DELAY, default 50000, post-reset wait in clk cycles (1 ms @ 50 MHz, minimum 1).
REQ-007 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port boot_sel  input  SEL_WIDTH  requested image index, sampled in SAMPLE state only.
REQ-010 SHALL have port boot_req  input  1  single-cycle runtime request to re-sample boot_sel and reconfigure.
REQ-011 SHALL have port ru_busy  input  1  remote-update core busy flag.
REQ-012 SHALL have port ru_write  output  1  one-cycle strobe loading ru_address into remote-update core.
REQ-013 SHALL have port ru_address  output  ADDR_WIDTH  start address of selected image.
REQ-014 SHALL have port ru_reconfig  output  1  one-cycle reconfiguration trigger.
REQ-015 SHALL have port busy  output  1  high in every state except DONE.
REQ-016 SHALL have port sel_error  output  1  sticky flag: last sampled boot_sel >= IMAGE_NUM.
REQ-017 SHALL have port image_index  output  SEL_WIDTH  last accepted image index.

Function
REQ-018 SHALL implement states DELAY, SAMPLE, LOAD, WAIT_LOAD, TRIGGER, HALT, DONE.
REQ-019 DELAY SHALL count clk cycles from 0; at count STARTUP_DELAY-1 go to SAMPLE next cycle.
REQ-020 SAMPLE SHALL register boot_sel; if value >= IMAGE_NUM: set sel_error, leave image_index unchanged, go DONE.
REQ-021 SAMPLE with valid value 0 SHALL clear sel_error, set image_index=0, go DONE (factory image already running, no reconfig).
REQ-022 SAMPLE with valid value N>0 SHALL clear sel_error, set image_index=N, compute ru_address = IMAGE_BASE + N*IMAGE_STRIDE truncated to ADDR_WIDTH, go LOAD.
REQ-023 LOAD SHALL wait while ru_busy=1; on first cycle with ru_busy=0 assert ru_write for exactly that cycle, go WAIT_LOAD.
REQ-024 WAIT_LOAD SHALL ignore ru_busy for one cycle, then wait for ru_busy=0 and go TRIGGER.
REQ-025 TRIGGER SHALL assert ru_reconfig for exactly one cycle, then go HALT.
REQ-026 HALT SHALL hold all strobes low and remain until reset; boot_req ignored.
REQ-027 DONE SHALL go to SAMPLE on the cycle after boot_req=1; boot_req in any other state SHALL be ignored (not queued).
REQ-028 ru_address SHALL hold its value outside SAMPLE; ru_write and ru_reconfig SHALL never be high in the same cycle.
REQ-029 Delay counter width SHALL be clog2(STARTUP_DELAY+1); no wrap-around permitted.

Reset
REQ-030 reset=1 SHALL, on the next clk edge, force state DELAY, counter 0, ru_write=0, ru_reconfig=0, ru_address=IMAGE_BASE, image_index=0, sel_error=0, busy=1.
REQ-031 reset asserted mid-operation (any state incl. LOAD/WAIT_LOAD/HALT) SHALL abort without emitting any further strobe and restart from DELAY.

Verification
REQ-032 STARTUP_DELAY=10, boot_sel=2, ru_busy=0 -> ru_write pulse with ru_address=24'h200000, then one ru_reconfig pulse, state HALT, busy=1.
REQ-033 boot_sel=0 after delay -> no ru_write/ru_reconfig, busy=0 at cycle STARTUP_DELAY+2, image_index=0.
REQ-034 IMAGE_NUM=3, boot_sel=3 -> sel_error=1, busy=0, no strobes; then boot_sel=1 + boot_req pulse -> sel_error=0, ru_address=24'h100000, reconfig sequence.
REQ-035 boot_sel=1, ru_busy held high 20 cycles in LOAD -> ru_write appears on first ru_busy=0 cycle; ru_busy high 5 cycles after write -> ru_reconfig exactly one cycle after ru_busy falls to 0 and TRIGGER entered.
REQ-036 reset pulsed during WAIT_LOAD -> no ru_reconfig, outputs at reset values, full sequence restarts after STARTUP_DELAY.
